uart_rx_cfg_receiver: RTL
=========================

Name: uart_rx_cfg_receiver

Overview:
- Parametrised, fully registered UART receiver: synchroniser, state registers, bit/clock counters and output registers in one block.
- Successor to the 8N1-only receive state machine.
- Adds configurable data width, optional parity, 1 or 2 stop bits, start-glitch rejection, and sticky-per-frame parity/framing error flags.
- Sits between the FPGA RX pin and the command/byte FIFO logic.

Parameters:
- CLKS_PER_BIT, 5208, i_Clock cycles per bit (>= 8).
- DATA_BITS, 8, data bits per frame, legal range 5..9.
- PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, stop bits expected, 1 or 2.

Ports:
- i_Clock  in  1  system clock.
- i_Reset  in  1  synchronous, active-high reset.
- i_Enable  in  1  receiver enable; low forces IDLE.
- i_Rx_Serial  in  1  asynchronous serial line, idle high.
- o_Rx_DV  out  1  one-cycle pulse: frame complete, outputs valid.
- o_Rx_Byte  out  DATA_BITS  received data, LSB = first bit on the line.
- o_Parity_Err  out  1  parity mismatch on the last frame; always 0 when PARITY_MODE=0.
- o_Frame_Err  out  1  at least one stop bit sampled low on the last frame.
- o_Busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (sampled on the i_Clock edge with i_Reset=1):
  - State IDLE; counters 0.
  - Synchroniser flops set to 1.
  - o_Rx_DV, o_Rx_Byte, o_Parity_Err, o_Frame_Err, o_Busy all 0.
  - Reset mid-frame abandons the frame; no DV is issued.
- i_Rx_Serial passes through a 2-flop synchroniser. All decisions use the synchronised bit (rx_s), giving 2 cycles of input latency.
- Clock counter width is $clog2(CLKS_PER_BIT). Bit index width is $clog2(DATA_BITS).
- States: IDLE, START, DATA, PARITY, STOP, CLEANUP.
- IDLE:
  - Counters are held at 0.
  - rx_s=0 with i_Enable=1 -> START.
- START:
  - Count up to (CLKS_PER_BIT-1)/2, then sample.
  - rx_s=0 -> DATA with the counter cleared.
  - rx_s=1 -> IDLE (glitch rejected); no flags change.
- DATA:
  - At count==CLKS_PER_BIT-1, shift the sample into byte[index] and clear the counter.
  - index==DATA_BITS-1 -> PARITY if PARITY_MODE!=0, else STOP. Otherwise index+1.
  - index is cleared on leaving DATA.
- PARITY:
  - Sample at full-bit time.
  - Expected bit is ^data for even and ~^data for odd.
  - A mismatch sets the internal parity-error flag.
  - Then -> STOP.
- STOP:
  - Sample at full-bit time, STOP_BITS times, using the stop counter.
  - Any low sample sets the internal framing-error flag.
  - After the last stop sample, in that same cycle:
    - o_Rx_DV=1 for exactly one cycle.
    - o_Rx_Byte and both error outputs are loaded from the internal registers.
  - Then -> CLEANUP.
- CLEANUP: one cycle; clears the internal error flags; -> IDLE.
- Output holding:
  - o_Rx_Byte and the error outputs hold their values until the next DV.
  - A frame with errors still asserts DV.
- i_Enable=0 in any state:
  - Next state is IDLE, counters and internal flags cleared, no DV.
  - Registered outputs hold their values.
- Back-to-back frames: a start edge during CLEANUP is caught on the following IDLE cycle (rx_s is still low). Minimum one idle cycle between frames.
- Latency: o_Rx_DV asserts CLKS_PER_BIT-1 cycles after the center of the last stop bit's preceding bit boundary, i.e. at the last stop bit center, plus the 2-cycle synchroniser delay.

Optional Feature:
- Macro: UART_RX_MAJORITY_VOTE_EN.
- Defined:
  - Every DATA, PARITY and STOP sample is the 2-of-3 majority of rx_s at counts CLKS_PER_BIT-3, -2 and -1.
  - The decision is made at -1, so the timing of state transitions is unchanged.
  - START validation remains single-sample.
- Undefined: single sample at CLKS_PER_BIT-1; the vote logic is not instantiated.

Decomposition:
- Package uart_rx_pkg:
  - state enum uart_rx_state_e (3 bits).
  - Parity constants PAR_NONE, PAR_EVEN, PAR_ODD.
  - Function for the counter width.
- Sub-module uart_rx_bit_sampler contains:
  - The synchroniser.
  - The vote shift register, when the macro is enabled.
  - Outputs: rx_s and the sampled bit.
- The FSM, counters and output registers stay in the top module.

Test Plan (all tests use CLKS_PER_BIT=16):
- 8N1, send 0xA5 -> o_Rx_DV pulses once with o_Rx_Byte=0xA5, o_Parity_Err=0 and o_Frame_Err=0; o_Busy falls 1 cycle later.
- Glitch test: drive a 5-cycle low pulse, then return to idle -> state returns to IDLE, no DV; then send 0x3C -> 0x3C received correctly.
- Parity tests (DATA_BITS=7, PARITY_MODE=2, STOP_BITS=2):
  - Send 0x55 with a correct parity bit -> DV with the error flags clear.
  - Same frame with the parity bit flipped -> o_Parity_Err=1.
- Second stop bit held low (STOP_BITS=2) -> DV with o_Frame_Err=1 and o_Rx_Byte still correct; the next clean frame clears the flag.
- Mid-frame interruptions during DATA bit 3:
  - Assert i_Reset -> all outputs 0, no DV; the next frame 0x81 is received.
  - Repeat the frame with i_Enable dropped instead of reset -> no DV, previous o_Rx_Byte held.
- With UART_RX_MAJORITY_VOTE_EN: inject a 1-cycle inverted spike at count 14 of each data bit of 0xF0 -> received as 0xF0. Without the macro, the same spike at count 15 corrupts the byte.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the configurable UART receiver.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_PARITY  = 3'd3,
        ST_STOP    = 3'd4,
        ST_CLEANUP = 3'd5
    } uart_rx_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Counter width for a count range of n, never narrower than one bit.
    function automatic int cnt_width(input int n);
        if (n <= 2) return 1;
        return $clog2(n);
    endfunction

endpackage

// File: rtl/uart_rx_bit_sampler.sv
// Two-flop RX synchroniser plus optional 2-of-3 vote (UART_RX_MAJORITY_VOTE_EN).
module uart_rx_bit_sampler (
    input  logic clk,
    input  logic rst,
    input  logic rx_serial,
    output logic rx_s,
    output logic sample_bit
);

    logic rx_meta_p0;
    logic rx_s_p1;

    // Synchroniser stages: p0 may be metastable, p1 is the clean line
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_p0 <= 1'b1;
            rx_s_p1    <= 1'b1;
        end else begin
            rx_meta_p0 <= rx_serial;
            rx_s_p1    <= rx_meta_p0;
        end
    end

    assign rx_s = rx_s_p1;

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic [1:0] hist_p2;

    // History of the two previous rx_s values; with the live value this spans counts -3..-1
    always_ff @(posedge clk) begin
        if (rst) hist_p2 <= 2'b11;
        else     hist_p2 <= {hist_p2[0], rx_s_p1};
    end

    assign sample_bit = (hist_p2[1] & hist_p2[0]) |
                        (hist_p2[1] & rx_s_p1)    |
                        (hist_p2[0] & rx_s_p1);
`else
    assign sample_bit = rx_s_p1;
`endif

endmodule

// File: rtl/uart_rx_cfg_receiver.sv
// Configurable UART receiver (5..9 data bits, none/even/odd parity, 1-2 stop bits).
// Optional majority-vote sampling via UART_RX_MAJORITY_VOTE_EN.
module uart_rx_cfg_receiver
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic                 i_Enable,
    input  logic                 i_Rx_Serial,
    output logic                 o_Rx_DV,
    output logic [DATA_BITS-1:0] o_Rx_Byte,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
    output logic                 o_Busy
);

    localparam int CNT_W = cnt_width(CLKS_PER_BIT);
    localparam int IDX_W = cnt_width(DATA_BITS);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
    localparam logic LAST_STOP   = (STOP_BITS == 2);
    localparam logic PAR_EN      = (PARITY_MODE != PAR_NONE);
    localparam logic PAR_ODD_SEL = (PARITY_MODE == PAR_ODD);

    logic rx_s;
    logic sample_bit;

    uart_rx_bit_sampler u_sampler (
        .clk        (i_Clock),
        .rst        (i_Reset),
        .rx_serial  (i_Rx_Serial),
        .rx_s       (rx_s),
        .sample_bit (sample_bit)
    );

    uart_rx_state_e         state_q, state_nx;
    logic [CNT_W-1:0]       clk_cnt_q, clk_cnt_nx;
    logic [IDX_W-1:0]       bit_idx_q, bit_idx_nx;
    logic                   stop_cnt_q, stop_cnt_nx;
    logic [DATA_BITS-1:0]   data_q, data_nx;
    logic                   par_err_q, par_err_nx;
    logic                   frm_err_q, frm_err_nx;
    logic                   rx_dv_nx;
    logic [DATA_BITS-1:0]   rx_byte_nx;
    logic                   par_out_nx, frm_out_nx;
    logic                   busy_nx;

    always_comb begin
        state_nx    = state_q;
        clk_cnt_nx  = clk_cnt_q;
        bit_idx_nx  = bit_idx_q;
        stop_cnt_nx = stop_cnt_q;
        data_nx     = data_q;
        par_err_nx  = par_err_q;
        frm_err_nx  = frm_err_q;
        rx_dv_nx    = 1'b0;
        rx_byte_nx  = o_Rx_Byte;
        par_out_nx  = o_Parity_Err;
        frm_out_nx  = o_Frame_Err;

        if (!i_Enable) begin
            state_nx    = ST_IDLE;
            clk_cnt_nx  = '0;
            bit_idx_nx  = '0;
            stop_cnt_nx = 1'b0;
            par_err_nx  = 1'b0;
            frm_err_nx  = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    clk_cnt_nx  = '0;
                    bit_idx_nx  = '0;
                    stop_cnt_nx = 1'b0;
                    if (!rx_s) state_nx = ST_START;
                end
                ST_START: begin
                    if (clk_cnt_q == HALF_CNT) begin
                        clk_cnt_nx = '0;
                        state_nx   = rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        clk_cnt_nx = clk_cnt_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (clk_cnt_q == FULL_CNT) begin
                        clk_cnt_nx          = '0;
                        data_nx[bit_idx_q]  = sample_bit;
                        if (bit_idx_q == LAST_IDX) begin
                            bit_idx_nx = '0;
                            state_nx   = PAR_EN ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_idx_nx = bit_idx_q + 1'b1;
                        end
                    end else begin
                        clk_cnt_nx = clk_cnt_q + 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (clk_cnt_q == FULL_CNT) begin
                        clk_cnt_nx = '0;
                        if (sample_bit != ((^data_q) ^ PAR_ODD_SEL)) par_err_nx = 1'b1;
                        state_nx = ST_STOP;
                    end else begin
                        clk_cnt_nx = clk_cnt_q + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (clk_cnt_q == FULL_CNT) begin
                        clk_cnt_nx = '0;
                        if (!sample_bit) frm_err_nx = 1'b1;
                        // Outputs load on the last stop sample, including that sample's verdict
                        if (stop_cnt_q == LAST_STOP) begin
                            stop_cnt_nx = 1'b0;
                            rx_dv_nx    = 1'b1;
                            rx_byte_nx  = data_q;
                            par_out_nx  = PAR_EN & par_err_q;
                            frm_out_nx  = frm_err_nx;
                            state_nx    = ST_CLEANUP;
                        end else begin
                            stop_cnt_nx = 1'b1;
                        end
                    end else begin
                        clk_cnt_nx = clk_cnt_q + 1'b1;
                    end
                end
                ST_CLEANUP: begin
                    par_err_nx = 1'b0;
                    frm_err_nx = 1'b0;
                    state_nx   = ST_IDLE;
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    assign busy_nx = (state_nx != ST_IDLE);

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q      <= ST_IDLE;
            clk_cnt_q    <= '0;
            bit_idx_q    <= '0;
            stop_cnt_q   <= 1'b0;
            data_q       <= '0;
            par_err_q    <= 1'b0;
            frm_err_q    <= 1'b0;
            o_Rx_DV      <= 1'b0;
            o_Rx_Byte    <= '0;
            o_Parity_Err <= 1'b0;
            o_Frame_Err  <= 1'b0;
            o_Busy       <= 1'b0;
        end else begin
            state_q      <= state_nx;
            clk_cnt_q    <= clk_cnt_nx;
            bit_idx_q    <= bit_idx_nx;
            stop_cnt_q   <= stop_cnt_nx;
            data_q       <= data_nx;
            par_err_q    <= par_err_nx;
            frm_err_q    <= frm_err_nx;
            o_Rx_DV      <= rx_dv_nx;
            o_Rx_Byte    <= rx_byte_nx;
            o_Parity_Err <= par_out_nx;
            o_Frame_Err  <= frm_out_nx;
            o_Busy       <= busy_nx;
        end
    end

endmodule
